// File: rtl/md6_seq_mode.sv
// MD6 sequential-mode controller: feeds chunks to an external compression core,
// chains each result into the next chunk and formats the final digest.
module md6_seq_mode #(
  parameter int W  = 64,
  parameter int CW = 16,
  parameter int MW = 48,
  parameter int IW = 56
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [11:0]            d,
  input  logic [11:0]            r,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [MW*W-1:0]        msg_data,
  input  logic                   msg_last,
  input  logic [15:0]            msg_pad,
  output logic                   cf_start,
  output logic [(CW+MW)*W-1:0]   cf_message,
  output logic [IW-1:0]          cf_index,
  output logic                   cf_z,
  output logic [15:0]            cf_padding,
  output logic [11:0]            cf_rounds,
  output logic [11:0]            cf_d,
  input  logic                   cf_done,
  input  logic [CW*W-1:0]        cf_c,
  output logic                   digest_valid,
  input  logic                   digest_ready,
  output logic [511:0]           D,
  output logic                   busy,
  output logic                   error
);

  localparam int DWORDS = 512 / W;

  typedef enum logic [2:0] {IDLE, ACCEPT, LAUNCH, WAIT, OUT} state_t;

  state_t            state_q, state_d;
  logic [11:0]       d_q, d_d;
  logic [11:0]       r_q, r_d;
  logic [CW*W-1:0]   chain_q, chain_d;
  logic [IW-1:0]     index_q, index_d;
  logic [MW*W-1:0]   msg_q, msg_d;
  logic              last_q, last_d;
  logic [15:0]       pad_q, pad_d;
  logic              error_q, error_d;
  logic [511:0]      digest_q, digest_d;
  logic [511:0]      rev;
  logic [511:0]      digest_new;
  logic              d_legal;

  assign d_legal = (d == 12'd224) || (d == 12'd256) || (d == 12'd384) || (d == 12'd512);

  // Core word j lands at rev word j, so the first ceil(d/64) words sit in rev[d-1:0];
  // left-shifting by 512-d left-justifies them and drops the truncated top bits.
  always_comb begin
    rev = '0;
    for (int j = 0; j < DWORDS; j++) begin
      if (j < CW) rev[j*W +: W] = cf_c[(CW-1-j)*W +: W];
    end
    case (d_q)
      12'd224: digest_new = rev << 288;
      12'd256: digest_new = rev << 256;
      12'd384: digest_new = rev << 128;
      default: digest_new = rev;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    r_d      = r_q;
    chain_d  = chain_q;
    index_d  = index_q;
    msg_d    = msg_q;
    last_d   = last_q;
    pad_d    = pad_q;
    digest_d = digest_q;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (d_legal) begin
            d_d     = d;
            r_d     = r;
            chain_d = '0;
            index_d = '0;
            state_d = ACCEPT;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ACCEPT: begin
        if (msg_valid) begin
          msg_d   = msg_data;
          last_d  = msg_last;
          pad_d   = msg_pad;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (cf_done) begin
          chain_d = cf_c;
          index_d = index_q + IW'(1);
          if (last_q) begin
            digest_d = digest_new;
            state_d  = OUT;
          end else begin
            state_d  = ACCEPT;
          end
        end
      end
      OUT: if (digest_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      d_q      <= '0;
      r_q      <= '0;
      chain_q  <= '0;
      index_q  <= '0;
      msg_q    <= '0;
      last_q   <= 1'b0;
      pad_q    <= '0;
      error_q  <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      r_q      <= r_d;
      chain_q  <= chain_d;
      index_q  <= index_d;
      msg_q    <= msg_d;
      last_q   <= last_d;
      pad_q    <= pad_d;
      error_q  <= error_d;
      digest_q <= digest_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign msg_ready    = (state_q == ACCEPT);
  assign cf_start     = (state_q == LAUNCH);
  assign digest_valid = (state_q == OUT);
  assign error        = error_q;
  assign D            = digest_q;
  assign cf_message   = {chain_q, msg_q};
  assign cf_index     = index_q;
  assign cf_z         = last_q;
  assign cf_padding   = pad_q;
  assign cf_rounds    = r_q;
  assign cf_d         = d_q;

endmodule

// File: tb/tb_md6_seq_mode.sv
// Bench for md6_seq_mode: vector table plus randomized hashes against a
// bit-level digest model and an inline compression-core responder.
module tb_md6_seq_mode;
  localparam int W = 64, CW = 16, MW = 48, IW = 56;

  logic                 clk = 1'b0;
  logic                 reset, start, msg_valid, msg_last, cf_done, digest_ready;
  logic [11:0]          d_in, r_in;
  logic [MW*W-1:0]      msg_data;
  logic [15:0]          msg_pad;
  logic [CW*W-1:0]      cf_c;
  logic                 msg_ready, cf_start, cf_z, digest_valid, busy, error;
  logic [(CW+MW)*W-1:0] cf_message;
  logic [IW-1:0]        cf_index;
  logic [15:0]          cf_padding;
  logic [11:0]          cf_rounds, cf_d;
  logic [511:0]         D;

  md6_seq_mode #(.W(W), .CW(CW), .MW(MW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .d(d_in), .r(r_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_pad(msg_pad), .cf_start(cf_start),
    .cf_message(cf_message), .cf_index(cf_index), .cf_z(cf_z),
    .cf_padding(cf_padding), .cf_rounds(cf_rounds), .cf_d(cf_d),
    .cf_done(cf_done), .cf_c(cf_c), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .D(D), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] d;
    logic [11:0] r;
    int          nch;
    int          rdly;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [4095:0] v);
    logic [63:0] f = '0;
    for (int i = 0; i < 64; i++) f ^= v[64*i +: 64];
    return f;
  endfunction

  task automatic chk_wide(input string name, input logic [4095:0] act, input logic [4095:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got fold %h low %h expected fold %h low %h",
               name, fold(act), act[63:0], fold(exp), exp[63:0]);
    end
  endtask

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [MW*W-1:0] rand_msg();
    logic [MW*W-1:0] v;
    for (int i = 0; i < MW*W/32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Bit b of the concatenation {Cw[n-1]..Cw[0]} counted from its lsb is bit b%64
  // of word b/64; that concatenation occupies D[511:512-d].
  function automatic logic [511:0] model_digest(input int dbits, input logic [1023:0] c);
    logic [511:0] res = '0;
    logic [63:0]  w;
    for (int b = 0; b < dbits; b++) begin
      w = c[1023 - 64*(b/64) -: 64];
      res[512 - dbits + b] = w[b % 64];
    end
    return res;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!msg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("msg_ready_wait", msg_ready, 1);
  endtask

  task automatic run_hash(input logic [11:0] dd, input logic [11:0] rr, input int nch,
                          input int rdly, input bit exp_err);
    logic [1023:0]   chain;
    logic [1023:0]   c;
    logic [MW*W-1:0] data;
    logic [15:0]     pad;
    logic [511:0]    exp_d;
    int              lat;
    @(negedge clk);
    start = 1'b1; d_in = dd; r_in = rr;
    @(negedge clk);
    start = 1'b0; d_in = 12'($urandom()); r_in = 12'($urandom());
    if (exp_err) begin
      chk($sformatf("err_pulse d=%0d", dd), error, 1);
      chk("err_busy", busy, 0);
      chk("err_msg_ready", msg_ready, 0);
      @(negedge clk);
      chk("err_fall", error, 0);
      chk("err_busy2", busy, 0);
      chk("err_msg_ready2", msg_ready, 0);
      return;
    end
    chk("start_no_err", error, 0);
    chk("start_busy", busy, 1);
    chain = '0;
    for (int i = 0; i < nch; i++) begin
      if (i > 0) begin
        // a completion pulse while waiting for data must not disturb the chain
        cf_done = 1'b1; cf_c = rand1024();
        @(negedge clk);
        cf_done = 1'b0;
      end
      wait_ready();
      data = rand_msg(); pad = 16'($urandom());
      msg_valid = 1'b1; msg_data = data; msg_last = (i == nch-1); msg_pad = pad;
      @(negedge clk);
      msg_valid = 1'b0; msg_data = rand_msg(); msg_last = 1'($urandom()); msg_pad = 16'($urandom());
      chk("cf_start_hi", cf_start, 1);
      chk("msg_ready_lo", msg_ready, 0);
      chk_wide($sformatf("cf_message chunk %0d", i), cf_message, {chain, data});
      chk("cf_index", cf_index, 64'(i));
      chk("cf_z", cf_z, (i == nch-1));
      chk("cf_padding", cf_padding, pad);
      chk("cf_rounds", cf_rounds, rr);
      chk("cf_d", cf_d, dd);
      lat = $urandom_range(0, 3);
      @(negedge clk);
      chk("cf_start_single", cf_start, 0);
      repeat (lat) @(negedge clk);
      chk_wide("cf_message_held", cf_message, {chain, data});
      c = rand1024();
      cf_c = c; cf_done = 1'b1;
      @(negedge clk);
      cf_done = 1'b0; cf_c = rand1024();
      chain = c;
      if (i < nch-1) begin
        chk("next_accept", msg_ready, 1);
        chk("no_early_digest", digest_valid, 0);
      end
    end
    exp_d = model_digest(int'(dd), chain);
    chk("digest_valid", digest_valid, 1);
    chk_wide($sformatf("D d=%0d", dd), D, exp_d);
    for (int k = 0; k < rdly; k++) begin
      if (k == 1) begin start = 1'b1; d_in = 12'd256; end
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid", digest_valid, 1);
      chk("hold_busy", busy, 1);
      chk_wide("hold_D", D, exp_d);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("valid_fall", digest_valid, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("idle_msg_ready", msg_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] rd;
    logic [MW*W-1:0] data;
    reset = 1'b1; start = 1'b0; d_in = '0; r_in = '0; msg_valid = 1'b0;
    msg_data = '0; msg_last = 1'b0; msg_pad = '0; cf_done = 1'b0; cf_c = '0;
    digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_cf_start", cf_start, 0);
    chk("rst_digest_valid", digest_valid, 0);
    chk("rst_error", error, 0);
    chk_wide("rst_D", D, '0);
    chk_wide("rst_cf_message", cf_message, '0);
    chk("rst_cf_index", cf_index, 0);
    chk("rst_cf_z", cf_z, 0);
    chk("rst_cf_padding", cf_padding, 0);
    chk("rst_cf_rounds", cf_rounds, 0);
    chk("rst_cf_d", cf_d, 0);

    tbl[0] = '{12'd256,  12'd104, 1, 0,  1'b0};
    tbl[1] = '{12'd512,  12'd80,  3, 1,  1'b0};
    tbl[2] = '{12'd224,  12'd96,  1, 0,  1'b0};
    tbl[3] = '{12'd300,  12'd104, 1, 0,  1'b1};
    tbl[4] = '{12'd384,  12'd40,  2, 10, 1'b0};
    tbl[5] = '{12'd0,    12'd5,   1, 0,  1'b1};
    tbl[6] = '{12'd4095, 12'd1,   1, 0,  1'b1};
    tbl[7] = '{12'd512,  12'd168, 1, 2,  1'b0};
    for (int t = 0; t < 8; t++)
      run_hash(tbl[t].d, tbl[t].r, tbl[t].nch, tbl[t].rdly, tbl[t].exp_err);

    // abort inside WAIT, then a stale completion must be ignored
    @(negedge clk);
    start = 1'b1; d_in = 12'd512; r_in = 12'd77;
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    data = rand_msg();
    msg_valid = 1'b1; msg_data = data; msg_last = 1'b1; msg_pad = 16'h0010;
    @(negedge clk);
    msg_valid = 1'b0;
    chk("abort_launch", cf_start, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cf_done = 1'b1; cf_c = rand1024();
    @(negedge clk);
    cf_done = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", digest_valid, 0);
    chk("abort_msg_ready", msg_ready, 0);
    chk("abort_cf_start", cf_start, 0);
    chk_wide("abort_D", D, '0);
    chk_wide("abort_cf_message", cf_message, '0);
    chk("abort_cf_index", cf_index, 0);
    chk("abort_cf_z", cf_z, 0);
    run_hash(12'd256, 12'd104, 2, 1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 4))
        0: rd = 12'd224;
        1: rd = 12'd256;
        2: rd = 12'd384;
        3: rd = 12'd512;
        default: begin
          rd = 12'($urandom());
          if (rd == 12'd224 || rd == 12'd256 || rd == 12'd384 || rd == 12'd512) rd = rd ^ 12'd1;
        end
      endcase
      run_hash(rd, 12'($urandom()), $urandom_range(1, 3), $urandom_range(0, 3),
               !(rd == 12'd224 || rd == 12'd256 || rd == 12'd384 || rd == 12'd512));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
